// File: rtl/uart_msg_pkg.sv
// Shared types, constants and the byte-format function for the miner response framer.
// Message layouts live here so the top only tracks type and byte index.
package uart_msg_pkg;

   typedef enum logic [2:0] {
      MSG_PONG,
      MSG_ACK,
      MSG_INFO,
      MSG_INVALID,
      MSG_NONCE
   } msg_type_t;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_t;

   typedef struct packed {
      logic pong;
      logic ack;
      logic invalid;
      logic info;
   } pend_t;

   localparam logic [7:0] TYPE_NONE    = 8'h00;
   localparam logic [7:0] TYPE_INVALID = 8'h01;
   localparam logic [7:0] TYPE_NONCE   = 8'h03;
   localparam logic [7:0] HDR_SHORT    = 8'h01;
   localparam logic [7:0] HDR_LONG     = 8'h08;
   localparam logic [7:0] HDR_INFO     = 8'h10;

   localparam int LEN_PONG    = 1;
   localparam int LEN_ACK     = 1;
   localparam int LEN_INFO    = 16;
   localparam int LEN_INVALID = 8;
   localparam int LEN_NONCE   = 8;

   function automatic logic [3:0] msg_last(msg_type_t t);
      int len;
      case (t)
         MSG_PONG:    len = LEN_PONG;
         MSG_ACK:     len = LEN_ACK;
         MSG_INFO:    len = LEN_INFO;
         MSG_INVALID: len = LEN_INVALID;
         default:     len = LEN_NONCE;
      endcase
      return 4'(len - 1);
   endfunction

   function automatic logic [7:0] word_byte(logic [31:0] w, logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [7:0] msg_byte(msg_type_t t, logic [3:0] idx,
                                           logic [31:0] info0, logic [31:0] info1,
                                           logic [31:0] nonce);
      logic [7:0] b;
      b = TYPE_NONE;
      case (t)
         MSG_PONG, MSG_ACK: b = HDR_SHORT;
         MSG_INFO: begin
            if (idx == 4'd0)            b = HDR_INFO;
            else if (idx[3:2] == 2'd1)  b = word_byte(info0, idx[1:0]);
            else if (idx[3:2] == 2'd2)  b = word_byte(info1, idx[1:0]);
         end
         MSG_INVALID: begin
            if (idx == 4'd0)       b = HDR_LONG;
            else if (idx == 4'd3)  b = TYPE_INVALID;
         end
         MSG_NONCE: begin
            if (idx == 4'd0)            b = HDR_LONG;
            else if (idx == 4'd3)       b = TYPE_NONCE;
            else if (idx[3:2] == 2'd1)  b = word_byte(nonce, idx[1:0]);
         end
         default: ;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_msg_tx_nonce_fifo.sv
// Golden-nonce queue: single clock, power-of-2 depth, head visible on dout while not empty.
// A push into a full queue is accepted only when a pop frees the slot in the same cycle.
module nonce_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is not reset; emptying the pointers is enough to clear the queue.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_msg_tx.sv
// Miner response framer: latches reply requests and golden nonces, then streams one
// protocol message at a time to the UART byte serializer over a valid/ready handshake.
module uart_msg_tx
   import uart_msg_pkg::*;
#(
   parameter int          NONCE_FIFO_DEPTH = 4,
   parameter logic [31:0] INFO_WORD0       = 32'hDEADBEEF,
   parameter logic [31:0] INFO_WORD1       = 32'h13370D13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ping_req,
   input  logic        ack_req,
   input  logic        info_req,
   input  logic        invalid_req,
   input  logic        nonce_valid,
   input  logic [31:0] nonce_in,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        nonce_ovf
);

   state_t      state_q, state_d;
   pend_t       pend_q, pend_d;
   msg_type_t   type_q, sel_type;
   logic        sel_valid;
   logic        load;
   logic        xfer;
   logic [3:0]  idx_q;
   logic [31:0] nonce_q;
   logic        ovf_q;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [31:0] fifo_dout;

   nonce_fifo #(
      .DEPTH (NONCE_FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (nonce_valid),
      .pop   (fifo_pop),
      .din   (nonce_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      sel_valid = 1'b1;
      sel_type  = MSG_PONG;
      if (pend_q.pong)         sel_type = MSG_PONG;
      else if (pend_q.ack)     sel_type = MSG_ACK;
      else if (pend_q.invalid) sel_type = MSG_INVALID;
      else if (pend_q.info)    sel_type = MSG_INFO;
      else if (!fifo_empty)    sel_type = MSG_NONCE;
      else                     sel_valid = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      xfer    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid) begin
               state_d = ST_SEND;
               load    = 1'b1;
            end
         end
         ST_SEND: begin
            xfer = tx_ready;
            if (tx_ready && idx_q == msg_last(type_q)) state_d = ST_IDLE;
         end
      endcase
      fifo_pop  = load && (sel_type == MSG_NONCE);
      tx_valid  = (state_q == ST_SEND);
      busy      = tx_valid;
      nonce_ovf = ovf_q;
      tx_data   = tx_valid ? msg_byte(type_q, idx_q, INFO_WORD0, INFO_WORD1, nonce_q) : 8'h00;
   end

   // A request landing in the same cycle its flag is consumed stays pending for the next message.
   always_comb begin
      pend_d = pend_q;
      if (load) begin
         case (sel_type)
            MSG_PONG:    pend_d.pong    = 1'b0;
            MSG_ACK:     pend_d.ack     = 1'b0;
            MSG_INVALID: pend_d.invalid = 1'b0;
            MSG_INFO:    pend_d.info    = 1'b0;
            default: ;
         endcase
      end
      if (ping_req)    pend_d.pong    = 1'b1;
      if (ack_req)     pend_d.ack     = 1'b1;
      if (invalid_req) pend_d.invalid = 1'b1;
      if (info_req)    pend_d.info    = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         type_q  <= MSG_PONG;
         idx_q   <= '0;
         nonce_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (load) begin
            type_q <= sel_type;
            idx_q  <= '0;
            if (sel_type == MSG_NONCE) nonce_q <= fifo_dout;
         end else if (xfer) begin
            idx_q <= idx_q + 4'd1;
         end
         if (nonce_valid && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx: directed scenarios plus randomized request batches
// compared against a byte-stream model built from the message formats.
module tb_uart_msg_tx;

   localparam logic [31:0] INFO0 = 32'hDEADBEEF;
   localparam logic [31:0] INFO1 = 32'h13370D13;
   localparam int K_PONG = 0, K_ACK = 1, K_INFO = 2, K_INVALID = 3, K_NONCE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ping_req = 1'b0, ack_req = 1'b0, info_req = 1'b0, invalid_req = 1'b0;
   logic        nonce_valid = 1'b0;
   logic [31:0] nonce_in = '0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid, busy, nonce_ovf;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          got_cyc[$];
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

   uart_msg_tx #(
      .NONCE_FIFO_DEPTH (4),
      .INFO_WORD0       (INFO0),
      .INFO_WORD1       (INFO1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ping_req    (ping_req),
      .ack_req     (ack_req),
      .info_req    (info_req),
      .invalid_req (invalid_req),
      .nonce_valid (nonce_valid),
      .nonce_in    (nonce_in),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .nonce_ovf   (nonce_ovf)
   );

   always #5 clk = ~clk;

   // Reference model: append the bytes of one message in send order.
   task automatic add_msg(input int kind, input logic [31:0] n);
      logic [31:0] w;
      case (kind)
         K_PONG, K_ACK: exp_q.push_back(8'h01);
         K_INFO: begin
            exp_q.push_back(8'h10);
            repeat (3) exp_q.push_back(8'h00);
            w = INFO0;
            for (int k = 3; k >= 0; k--) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
            w = INFO1;
            for (int k = 3; k >= 0; k--) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
            repeat (4) exp_q.push_back(8'h00);
         end
         K_INVALID: begin
            exp_q.push_back(8'h08);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h01);
            repeat (4) exp_q.push_back(8'h00);
         end
         default: begin
            exp_q.push_back(8'h08);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h03);
            for (int k = 3; k >= 0; k--) exp_q.push_back(8'((n >> (8 * k)) & 32'hFF));
         end
      endcase
   endtask

   // One clock: observe at the falling edge, then return just after the rising edge.
   task automatic step(input bit rnd);
      @(negedge clk);
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required 1 and %h",
                        tx_valid, tx_data, prev_data);
            end
         end
         if (tx_valid === 1'b1 && tx_ready) begin
            got_q.push_back(tx_data);
            got_cyc.push_back(cyc);
         end
         prev_stall = (tx_valid === 1'b1) && !tx_ready;
         prev_data  = tx_data;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drain(input int n, input bit rnd, output bit ok);
      int k = 0;
      while (got_q.size() < n && k < 4000) begin
         step(rnd);
         k++;
      end
      ok = (got_q.size() >= n);
      tx_ready = 1'b1;
      repeat (6) step(1'b0);
   endtask

   task automatic clear_streams();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || nonce_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: valid=%b data=%h busy=%b ovf=%b, required 0 00 0 0",
                  tx_valid, tx_data, busy, nonce_ovf);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0);
   endtask

   task automatic test_ping();
      clear_streams();
      ping_req = 1'b1;
      step(1'b0);
      ping_req = 1'b0;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ping_edge_n: valid=%b busy=%b, required 0 0", tx_valid, busy);
      end
      step(1'b0);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h01 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ping_edge_n1: valid=%b data=%h busy=%b, required 1 01 1",
                  tx_valid, tx_data, busy);
      end
      step(1'b0);
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ping_done: valid=%b busy=%b, required 0 0", tx_valid, busy);
      end
      repeat (5) step(1'b0);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h01) begin
         errors++;
         $display("FAIL ping_stream: got %0d bytes (first %h), required 1 byte 01",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
   endtask

   task automatic test_info();
      bit ok;
      clear_streams();
      add_msg(K_INFO, 32'h0);
      info_req = 1'b1;
      step(1'b0);
      info_req = 1'b0;
      drain(exp_q.size(), 1'b0, ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL info_len: got %0d bytes, required %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL info_byte %0d: got %h, required %h", k, got_q[k], exp_q[k]);
         end
      end
      if (got_cyc.size() == 16) begin
         checks++;
         if (got_cyc[15] - got_cyc[0] != 15) begin
            errors++;
            $display("FAIL info_gapless: span %0d cycles, required 15", got_cyc[15] - got_cyc[0]);
         end
      end
   endtask

   task automatic test_nonce_stall();
      bit ok;
      clear_streams();
      add_msg(K_NONCE, 32'h1DAC2B7C);
      nonce_valid = 1'b1;
      nonce_in    = 32'h1DAC2B7C;
      step(1'b1);
      nonce_valid = 1'b0;
      drain(exp_q.size(), 1'b1, ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL nonce_len: got %0d bytes, required %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL nonce_byte %0d: got %h, required %h", k, got_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_invalid_and_nonce();
      bit ok;
      clear_streams();
      add_msg(K_INVALID, 32'h0);
      add_msg(K_NONCE, 32'h00000001);
      invalid_req = 1'b1;
      nonce_valid = 1'b1;
      nonce_in    = 32'h00000001;
      step(1'b0);
      invalid_req = 1'b0;
      nonce_valid = 1'b0;
      drain(exp_q.size(), 1'b0, ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL inv_nonce_len: got %0d bytes, required %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL inv_nonce_byte %0d: got %h, required %h", k, got_q[k], exp_q[k]);
         end
      end
      if (got_cyc.size() == 16) begin
         checks++;
         if (got_cyc[8] - got_cyc[7] < 2) begin
            errors++;
            $display("FAIL inv_nonce_gap: %0d cycles between messages, required >= 2",
                     got_cyc[8] - got_cyc[7]);
         end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      logic [31:0] v;
      clear_streams();
      tx_ready = 1'b0;
      add_msg(K_PONG, 32'h0);
      ping_req = 1'b1;
      step(1'b0);
      ping_req = 1'b0;
      step(1'b0);
      for (int k = 0; k < 5; k++) begin
         v = $urandom;
         if (k < 4) add_msg(K_NONCE, v);
         nonce_valid = 1'b1;
         nonce_in    = v;
         step(1'b0);
      end
      nonce_valid = 1'b0;
      step(1'b0);
      checks++;
      if (nonce_ovf !== 1'b1 || busy !== 1'b1 || got_q.size() != 0) begin
         errors++;
         $display("FAIL ovf_stalled: ovf=%b busy=%b bytes=%0d, required 1 1 0",
                  nonce_ovf, busy, got_q.size());
      end
      tx_ready = 1'b1;
      drain(exp_q.size(), 1'b0, ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL ovf_len: got %0d bytes, required %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL ovf_byte %0d: got %h, required %h", k, got_q[k], exp_q[k]);
         end
      end
      checks++;
      if (nonce_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%b, required 1", nonce_ovf);
      end
   endtask

   task automatic test_reset_mid_message();
      int k = 0;
      clear_streams();
      info_req = 1'b1;
      step(1'b0);
      info_req = 1'b0;
      while (got_q.size() < 6 && k < 100) begin
         step(1'b0);
         k++;
      end
      checks++;
      if (got_q.size() != 6) begin
         errors++;
         $display("FAIL rst_mid_start: got %0d bytes before reset, required 6", got_q.size());
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || nonce_ovf !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: valid=%b data=%h busy=%b ovf=%b, required 0 00 0 0",
                  tx_valid, tx_data, busy, nonce_ovf);
      end
      repeat (3) step(1'b0);
      rst_n = 1'b1;
      repeat (30) step(1'b0);
      checks++;
      if (got_q.size() != 6 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_resume: bytes=%0d valid=%b, required 6 0", got_q.size(), tx_valid);
      end
   endtask

   task automatic test_random_batches();
      bit ok;
      bit p, a, i, v, n;
      int m;
      logic [31:0] w;
      for (int it = 0; it < 20; it++) begin
         clear_streams();
         p = 1'($urandom_range(0, 1));
         a = 1'($urandom_range(0, 1));
         i = 1'($urandom_range(0, 1));
         v = 1'($urandom_range(0, 1));
         n = 1'($urandom_range(0, 1));
         if (!(p || a || i || v || n)) p = 1'b1;
         w = $urandom;
         if (p) add_msg(K_PONG, 32'h0);
         if (a) add_msg(K_ACK, 32'h0);
         if (v) add_msg(K_INVALID, 32'h0);
         if (i) add_msg(K_INFO, 32'h0);
         if (n) add_msg(K_NONCE, w);
         ping_req = p; ack_req = a; info_req = i; invalid_req = v;
         nonce_valid = n; nonce_in = w;
         step(1'b1);
         ping_req = 1'b0; ack_req = 1'b0; info_req = 1'b0; invalid_req = 1'b0;
         nonce_valid = 1'b0;
         m = $urandom_range(0, 2);
         for (int j = 0; j < m; j++) begin
            w = $urandom;
            add_msg(K_NONCE, w);
            nonce_valid = 1'b1;
            nonce_in    = w;
            step(1'b1);
            nonce_valid = 1'b0;
         end
         drain(exp_q.size(), 1'b1, ok);
         checks++;
         if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_len iter %0d: got %0d bytes, required %0d",
                     it, got_q.size(), exp_q.size());
         end
         for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
               errors++;
               $display("FAIL rand_byte iter %0d byte %0d: got %h, required %h",
                        it, k, got_q[k], exp_q[k]);
            end
         end
      end
      checks++;
      if (nonce_ovf !== 1'b0) begin
         errors++;
         $display("FAIL rand_no_ovf: ovf=%b, required 0", nonce_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_ping();
      test_info();
      test_nonce_stall();
      test_invalid_and_nonce();
      test_random_batches();
      test_overflow();
      test_reset_mid_message();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
